jk_cmd_sequencer: RTL and testbench

JK_CMD_SEQUENCER -- requirements
Module: jk_cmd_sequencer

---
 rtl/jk_cmd_sequencer.sv | 124 ++++++++++++
 tb/tb_jk_cmd_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/jk_cmd_sequencer.sv
// Command-queued JK flip-flop bank driver: FIFO of {op, mask, repeat} commands issued as registered J/K drive.
// Optional macro JK_SEQ_SHADOW_EN adds shadow_q, a model of the driven JK bank.
module jk_cmd_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [CNT_W-1:0] cmd_rpt,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
`ifdef JK_SEQ_SHADOW_EN
    output logic [WIDTH-1:0] shadow_q,
`endif
    output logic             busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef struct packed {
        logic [1:0]       op;
        logic [WIDTH-1:0] mask;
        logic [CNT_W-1:0] rpt;
    } cmd_t;

    typedef enum logic {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_t;

    cmd_t             r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_j, r_k, w_j_nxt, w_k_nxt;
    logic             w_empty, w_full, w_push, w_pop, w_load;
    cmd_t             w_head, w_in;

    // Extra pointer bit separates full from empty when the indices match
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = cmd_valid && !w_full && !rst;
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];
    assign w_in    = '{op: cmd_op, mask: cmd_mask, rpt: cmd_rpt};

    assign cmd_ready = !w_full;
    assign busy      = (r_state == S_ISSUE) || !w_empty;
    assign j         = r_j;
    assign k         = r_k;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state, pop decision and the J/K drive for the coming cycle
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_j_nxt     = r_j;
        w_k_nxt     = r_k;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_j_nxt = '0;
                w_k_nxt = '0;
                if (!w_empty) w_load = 1'b1;
            end
            S_ISSUE: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt <= CNT_W'(1)) begin
                    if (!w_empty) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_j_nxt     = '0;
                        w_k_nxt     = '0;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_load) begin
            w_pop       = 1'b1;
            w_state_nxt = S_ISSUE;
            w_cnt_nxt   = (w_head.rpt == '0) ? CNT_W'(1) : w_head.rpt;
            w_j_nxt     = {WIDTH{w_head.op[1]}} & w_head.mask;
            w_k_nxt     = {WIDTH{w_head.op[0]}} & w_head.mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_j      <= '0;
            r_k      <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_cnt <= w_cnt_nxt;
            r_j   <= w_j_nxt;
            r_k   <= w_k_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_in;
    end

`ifdef JK_SEQ_SHADOW_EN
    // Q+ = J & ~Q | ~K & Q, using the drive presented during the cycle just ended
    always_ff @(posedge clk) begin
        if (rst) shadow_q <= '0;
        else     shadow_q <= (r_j & ~shadow_q) | (~r_k & shadow_q);
    end
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer: per-cycle vector table plus FIFO-full and mid-issue reset sequences.
module tb_jk_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_mask;
    logic [3:0] cmd_rpt;
    logic [7:0] j, k;
    logic       busy;
`ifdef JK_SEQ_SHADOW_EN
    logic [7:0] shadow_q;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    jk_cmd_sequencer #(.WIDTH(8), .DEPTH(4), .CNT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_mask (cmd_mask),
        .cmd_rpt  (cmd_rpt),
        .j        (j),
        .k        (k),
`ifdef JK_SEQ_SHADOW_EN
        .shadow_q (shadow_q),
`endif
        .busy     (busy)
    );

    typedef struct {
        logic       rst;
        logic       vld;
        logic [1:0] op;
        logic [7:0] mask;
        logic [3:0] rpt;
        logic       e_rdy;
        logic       e_busy;
        logic [7:0] e_j;
        logic [7:0] e_k;
        logic [7:0] e_sh;
    } vec_t;

    vec_t vt [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [1:0] o,
                         input logic [7:0] m, input logic [3:0] c);
        rst = r; cmd_valid = v; cmd_op = o; cmd_mask = m; cmd_rpt = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic v, input logic [1:0] o,
                                input logic [7:0] m, input logic [3:0] c,
                                input logic er, input logic eb, input logic [7:0] ej,
                                input logic [7:0] ek, input logic [7:0] es);
        vec_t t;
        t.rst = r; t.vld = v; t.op = o; t.mask = m; t.rpt = c;
        t.e_rdy = er; t.e_busy = eb; t.e_j = ej; t.e_k = ek; t.e_sh = es;
        return t;
    endfunction

    logic [7:0] seen_j [$];
    logic [7:0] seen_k [$];

    initial begin
        // Expected outputs are those visible just after the vector's clock edge
        vt[0]  = mk(1, 0, 2'b00, 8'h00, 4'd0, 1, 0, 8'h00, 8'h00, 8'h00);
        vt[1]  = mk(0, 1, 2'b10, 8'h05, 4'd1, 1, 1, 8'h00, 8'h00, 8'h00);
        vt[2]  = mk(0, 0, 2'b00, 8'h00, 4'd0, 1, 1, 8'h05, 8'h00, 8'h00);
        vt[3]  = mk(0, 0, 2'b00, 8'h00, 4'd0, 1, 0, 8'h00, 8'h00, 8'h05);
        vt[4]  = mk(0, 0, 2'b00, 8'h00, 4'd0, 1, 0, 8'h00, 8'h00, 8'h05);
        vt[5]  = mk(1, 0, 2'b00, 8'h00, 4'd0, 1, 0, 8'h00, 8'h00, 8'h00);
        vt[6]  = mk(0, 1, 2'b11, 8'h81, 4'd3, 1, 1, 8'h00, 8'h00, 8'h00);
        vt[7]  = mk(0, 0, 2'b00, 8'h00, 4'd0, 1, 1, 8'h81, 8'h81, 8'h00);
        vt[8]  = mk(0, 0, 2'b00, 8'h00, 4'd0, 1, 1, 8'h81, 8'h81, 8'h81);
        vt[9]  = mk(0, 0, 2'b00, 8'h00, 4'd0, 1, 1, 8'h81, 8'h81, 8'h00);
        vt[10] = mk(0, 0, 2'b00, 8'h00, 4'd0, 1, 0, 8'h00, 8'h00, 8'h81);
        vt[11] = mk(1, 0, 2'b00, 8'h00, 4'd0, 1, 0, 8'h00, 8'h00, 8'h00);
        vt[12] = mk(0, 1, 2'b01, 8'hFF, 4'd2, 1, 1, 8'h00, 8'h00, 8'h00);
        vt[13] = mk(0, 1, 2'b10, 8'h0F, 4'd0, 1, 1, 8'h00, 8'hFF, 8'h00);
        vt[14] = mk(0, 0, 2'b00, 8'h00, 4'd0, 1, 1, 8'h00, 8'hFF, 8'h00);
        vt[15] = mk(0, 0, 2'b00, 8'h00, 4'd0, 1, 1, 8'h0F, 8'h00, 8'h00);
        vt[16] = mk(0, 0, 2'b00, 8'h00, 4'd0, 1, 0, 8'h00, 8'h00, 8'h0F);
        vt[17] = mk(0, 1, 2'b00, 8'hFF, 4'd2, 1, 1, 8'h00, 8'h00, 8'h0F);
        vt[18] = mk(0, 0, 2'b00, 8'h00, 4'd0, 1, 1, 8'h00, 8'h00, 8'h0F);
        vt[19] = mk(0, 0, 2'b00, 8'h00, 4'd0, 1, 1, 8'h00, 8'h00, 8'h0F);
        vt[20] = mk(0, 0, 2'b00, 8'h00, 4'd0, 1, 0, 8'h00, 8'h00, 8'h0F);

        drive(1, 0, 2'b00, 8'h00, 4'd0);
        tick();

        for (int i = 0; i < 21; i++) begin
            drive(vt[i].rst, vt[i].vld, vt[i].op, vt[i].mask, vt[i].rpt);
            tick();
            check($sformatf("v%0d_ready", i), 32'(cmd_ready), 32'(vt[i].e_rdy));
            check($sformatf("v%0d_busy", i),  32'(busy),      32'(vt[i].e_busy));
            check($sformatf("v%0d_j", i),     32'(j),         32'(vt[i].e_j));
            check($sformatf("v%0d_k", i),     32'(k),         32'(vt[i].e_k));
`ifdef JK_SEQ_SHADOW_EN
            check($sformatf("v%0d_shadow", i), 32'(shadow_q), 32'(vt[i].e_sh));
`endif
        end

        // FIFO fills behind a 15-cycle hold; six set commands must each issue once, in order
        begin
            int  idx  = 0;
            bit  done = 0;
            logic rdy;
            logic [7:0] one = 8'h01;
            drive(1, 0, 2'b00, 8'h00, 4'd0);
            tick();
            drive(0, 1, 2'b00, 8'hFF, 4'd15);
            tick();
            for (int cyc = 0; cyc < 200; cyc++) begin
                drive(0, idx < 6, 2'b10, one << idx, 4'd1);
                rdy = cmd_ready;
                tick();
                if (cmd_valid && rdy) begin
                    idx++;
                    if (idx == 4) check("full_ready_low", 32'(cmd_ready), 32'd0);
                end
                if (j != 8'h00 || k != 8'h00) begin
                    seen_j.push_back(j);
                    seen_k.push_back(k);
                end
                if (idx == 6 && !busy && j == 8'h00) begin
                    done = 1;
                    break;
                end
            end
            check("fifo_drain_done", 32'(done), 32'd1);
            check("fifo_issue_count", 32'(seen_j.size()), 32'd6);
            for (int n = 0; n < 6 && n < seen_j.size(); n++) begin
                check($sformatf("fifo_j%0d", n), 32'(seen_j[n]), 32'(one << n));
                check($sformatf("fifo_k%0d", n), 32'(seen_k[n]), 32'd0);
            end
        end

        // Reset during the second repetition of a rpt=5 toggle with two commands queued
        drive(1, 0, 2'b00, 8'h00, 4'd0);
        tick();
        drive(0, 1, 2'b11, 8'h3C, 4'd5);
        tick();
        drive(0, 1, 2'b10, 8'hAA, 4'd2);
        tick();
        drive(0, 1, 2'b01, 8'h55, 4'd2);
        tick();
        check("mid_j_before_rst", 32'(j), 32'h3C);
        check("mid_k_before_rst", 32'(k), 32'h3C);
        drive(1, 1, 2'b10, 8'hF0, 4'd3);
        tick();
        check("rst_j", 32'(j), 32'd0);
        check("rst_k", 32'(k), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
`ifdef JK_SEQ_SHADOW_EN
        check("rst_shadow", 32'(shadow_q), 32'd0);
`endif
        drive(0, 0, 2'b00, 8'h00, 4'd0);
        tick();
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_j", 32'(j), 32'd0);
        tick();
        check("post_rst_busy2", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
